// File: rtl/axil_periph_router.sv
// ---------------------------------------------------------------------------
// axil_periph_router
//
// Routes one AXI-Lite slave port to NUM_SLOTS peripheral AXI-Lite ports.
// The target is chosen by address region: slot = addr[SLOT_LSB +: 3].
// Address bits above SLOT_LSB+2 are ignored, so the decode aliases.
// A slot index >= NUM_SLOTS gets a DECERR response and no peripheral is
// touched. One write and one read may be outstanding at the same time. The
// write and read FSMs are independent, even when both target the same slot.
//
// Optional feature: define AXIL_ROUTER_TIMEOUT_EN to add a per-FSM 16-bit
// watchdog. If a peripheral has not responded 1024 cycles after forwarding
// starts, the access is abandoned with SLVERR (read data 32'hDEAD_BEEF) and
// the sticky timeout_flag output is set. timeout_flag is cleared only by rst.
//
// Ports
//   clk, rst          single clock; synchronous active-high reset
//   s_axi_*           AXI-Lite slave (AW/W/B/AR/R channels)
//   m_awaddr/m_wdata/m_wstrb/m_araddr
//                     registered request fields, broadcast to all slots
//   m_*valid/m_*ready one bit per slot; only the selected slot's bit is used
//   m_bresp/m_rresp   2 bits per slot; m_rdata is 32 bits per slot
//   timeout_flag      sticky watchdog flag (AXIL_ROUTER_TIMEOUT_EN only)
// ---------------------------------------------------------------------------
module axil_periph_router #(
    parameter int NUM_SLOTS = 4,
    parameter int ADDR_W    = 32,
    parameter int LOCAL_AW  = 6,
    parameter int SLOT_LSB  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      s_axi_awaddr,
    input  logic                   s_axi_awvalid,
    output logic                   s_axi_awready,
    input  logic [31:0]            s_axi_wdata,
    input  logic [3:0]             s_axi_wstrb,
    input  logic                   s_axi_wvalid,
    output logic                   s_axi_wready,
    output logic [1:0]             s_axi_bresp,
    output logic                   s_axi_bvalid,
    input  logic                   s_axi_bready,
    input  logic [ADDR_W-1:0]      s_axi_araddr,
    input  logic                   s_axi_arvalid,
    output logic                   s_axi_arready,
    output logic [31:0]            s_axi_rdata,
    output logic [1:0]             s_axi_rresp,
    output logic                   s_axi_rvalid,
    input  logic                   s_axi_rready,
    output logic [LOCAL_AW-1:0]    m_awaddr,
    output logic [31:0]            m_wdata,
    output logic [3:0]             m_wstrb,
    output logic [NUM_SLOTS-1:0]   m_awvalid,
    input  logic [NUM_SLOTS-1:0]   m_awready,
    output logic [NUM_SLOTS-1:0]   m_wvalid,
    input  logic [NUM_SLOTS-1:0]   m_wready,
    input  logic [2*NUM_SLOTS-1:0] m_bresp,
    input  logic [NUM_SLOTS-1:0]   m_bvalid,
    output logic [NUM_SLOTS-1:0]   m_bready,
    output logic [LOCAL_AW-1:0]    m_araddr,
    output logic [NUM_SLOTS-1:0]   m_arvalid,
    input  logic [NUM_SLOTS-1:0]   m_arready,
    input  logic [32*NUM_SLOTS-1:0] m_rdata,
    input  logic [2*NUM_SLOTS-1:0] m_rresp,
    input  logic [NUM_SLOTS-1:0]   m_rvalid,
    output logic [NUM_SLOTS-1:0]   m_rready
`ifdef AXIL_ROUTER_TIMEOUT_EN
    ,
    output logic                   timeout_flag
`endif
);

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_FWD   = 2'd1,
        W_RESP  = 2'd2,
        W_BRESP = 2'd3
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_FWD  = 2'd1,
        R_WAIT = 2'd2,
        R_RESP = 2'd3
    } r_state_t;

    localparam logic [3:0]  NUM_SLOTS_L = 4'(NUM_SLOTS);
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
`ifdef AXIL_ROUTER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST    = 16'd1023;
`endif

    // One-hot slot select; only called with in-range slot indices.
    function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [2:0] slot);
        logic [NUM_SLOTS-1:0] oh;
        oh = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            oh[k] = (slot == 3'(k));
        end
        return oh;
    endfunction

    // ---------------- write path state ----------------
    w_state_t              w_state_r, w_state_nxt;
    logic [NUM_SLOTS-1:0]  w_sel_r, w_sel_nxt;
    logic                  w_idle_r;
    logic [LOCAL_AW-1:0]   m_awaddr_r, m_awaddr_nxt;
    logic [31:0]           m_wdata_r, m_wdata_nxt;
    logic [3:0]            m_wstrb_r, m_wstrb_nxt;
    logic [NUM_SLOTS-1:0]  m_awvalid_r, m_awvalid_nxt;
    logic [NUM_SLOTS-1:0]  m_wvalid_r, m_wvalid_nxt;
    logic [NUM_SLOTS-1:0]  m_bready_r, m_bready_nxt;
    logic                  s_bvalid_r, s_bvalid_nxt;
    logic [1:0]            s_bresp_r, s_bresp_nxt;
    logic                  w_accept_s;
    logic [2:0]            w_slot_s;
    logic                  w_miss_s;
    logic [1:0]            bresp_sel_s;

    // ---------------- read path state ----------------
    r_state_t              r_state_r, r_state_nxt;
    logic [NUM_SLOTS-1:0]  r_sel_r, r_sel_nxt;
    logic                  r_idle_r;
    logic [LOCAL_AW-1:0]   m_araddr_r, m_araddr_nxt;
    logic [NUM_SLOTS-1:0]  m_arvalid_r, m_arvalid_nxt;
    logic [NUM_SLOTS-1:0]  m_rready_r, m_rready_nxt;
    logic                  s_rvalid_r, s_rvalid_nxt;
    logic [1:0]            s_rresp_r, s_rresp_nxt;
    logic [31:0]           s_rdata_r, s_rdata_nxt;
    logic                  r_accept_s;
    logic [2:0]            r_slot_s;
    logic                  r_miss_s;
    logic [1:0]            rresp_sel_s;
    logic [31:0]           rdata_sel_s;

`ifdef AXIL_ROUTER_TIMEOUT_EN
    logic [15:0]           w_tmo_r, w_tmo_nxt;
    logic [15:0]           r_tmo_r, r_tmo_nxt;
    logic                  w_tmo_hit_s;
    logic                  r_tmo_hit_s;
    logic                  timeout_flag_r;
`endif

    // Upper address bits only alias the decode; fold them into a sink.
    logic unused_addr_bits_s;
    assign unused_addr_bits_s = ^{s_axi_awaddr, s_axi_araddr};

    // The w_idle_r/r_idle_r flags keep the ready outputs low while in reset.
    assign w_accept_s = w_idle_r & s_axi_awvalid & s_axi_wvalid;
    assign r_accept_s = r_idle_r & s_axi_arvalid;
    assign w_slot_s   = s_axi_awaddr[SLOT_LSB +: 3];
    assign r_slot_s   = s_axi_araddr[SLOT_LSB +: 3];
    assign w_miss_s   = ({1'b0, w_slot_s} >= NUM_SLOTS_L);
    assign r_miss_s   = ({1'b0, r_slot_s} >= NUM_SLOTS_L);

    // AND-OR mux of the selected slot's response fields.
    always_comb begin
        bresp_sel_s = 2'b00;
        rresp_sel_s = 2'b00;
        rdata_sel_s = 32'h0000_0000;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            bresp_sel_s = bresp_sel_s | (m_bresp[2*k +: 2]  & {2{w_sel_r[k]}});
            rresp_sel_s = rresp_sel_s | (m_rresp[2*k +: 2]  & {2{r_sel_r[k]}});
            rdata_sel_s = rdata_sel_s | (m_rdata[32*k +: 32] & {32{r_sel_r[k]}});
        end
    end

    // Write FSM next-state and next values of every write-side register.
    always_comb begin
        w_state_nxt   = w_state_r;
        w_sel_nxt     = w_sel_r;
        m_awaddr_nxt  = m_awaddr_r;
        m_wdata_nxt   = m_wdata_r;
        m_wstrb_nxt   = m_wstrb_r;
        m_awvalid_nxt = m_awvalid_r;
        m_wvalid_nxt  = m_wvalid_r;
        m_bready_nxt  = m_bready_r;
        s_bvalid_nxt  = s_bvalid_r;
        s_bresp_nxt   = s_bresp_r;
        case (w_state_r)
            W_IDLE: begin
                if (w_accept_s) begin
                    m_awaddr_nxt = s_axi_awaddr[LOCAL_AW-1:0];
                    m_wdata_nxt  = s_axi_wdata;
                    m_wstrb_nxt  = s_axi_wstrb;
                    if (w_miss_s) begin
                        w_sel_nxt    = '0;
                        s_bresp_nxt  = RESP_DECERR;
                        s_bvalid_nxt = 1'b1;
                        w_state_nxt  = W_BRESP;
                    end else begin
                        w_sel_nxt     = slot_onehot(w_slot_s);
                        m_awvalid_nxt = slot_onehot(w_slot_s);
                        m_wvalid_nxt  = slot_onehot(w_slot_s);
                        w_state_nxt   = W_FWD;
                    end
                end else begin
                    w_state_nxt = W_IDLE;
                end
            end
            W_FWD: begin
                // AW and W complete independently, in either order.
                m_awvalid_nxt = m_awvalid_r & ~m_awready;
                m_wvalid_nxt  = m_wvalid_r & ~m_wready;
                if ((m_awvalid_nxt == '0) && (m_wvalid_nxt == '0)) begin
                    m_bready_nxt = w_sel_r;
                    w_state_nxt  = W_RESP;
                end else begin
                    w_state_nxt = W_FWD;
                end
            end
            W_RESP: begin
                if ((m_bvalid & w_sel_r) != '0) begin
                    s_bresp_nxt  = bresp_sel_s;
                    s_bvalid_nxt = 1'b1;
                    m_bready_nxt = '0;
                    w_state_nxt  = W_BRESP;
                end else begin
                    w_state_nxt = W_RESP;
                end
            end
            W_BRESP: begin
                if (s_axi_bready) begin
                    s_bvalid_nxt = 1'b0;
                    w_state_nxt  = W_IDLE;
                end else begin
                    w_state_nxt = W_BRESP;
                end
            end
            default: begin
                w_state_nxt = W_IDLE;
            end
        endcase
`ifdef AXIL_ROUTER_TIMEOUT_EN
        w_tmo_nxt   = 16'd0;
        w_tmo_hit_s = 1'b0;
        if ((w_state_r == W_FWD) || (w_state_r == W_RESP)) begin
            // Abandon the slot unless it answers on this very cycle.
            if ((w_tmo_r == TMO_LAST) && (w_state_nxt != W_BRESP)) begin
                w_tmo_hit_s   = 1'b1;
                m_awvalid_nxt = '0;
                m_wvalid_nxt  = '0;
                m_bready_nxt  = '0;
                s_bresp_nxt   = RESP_SLVERR;
                s_bvalid_nxt  = 1'b1;
                w_state_nxt   = W_BRESP;
            end else begin
                w_tmo_nxt = w_tmo_r + 16'd1;
            end
        end else begin
            w_tmo_nxt = 16'd0;
        end
`endif
    end

    // Read FSM next-state and next values of every read-side register.
    always_comb begin
        r_state_nxt   = r_state_r;
        r_sel_nxt     = r_sel_r;
        m_araddr_nxt  = m_araddr_r;
        m_arvalid_nxt = m_arvalid_r;
        m_rready_nxt  = m_rready_r;
        s_rvalid_nxt  = s_rvalid_r;
        s_rresp_nxt   = s_rresp_r;
        s_rdata_nxt   = s_rdata_r;
        case (r_state_r)
            R_IDLE: begin
                if (r_accept_s) begin
                    m_araddr_nxt = s_axi_araddr[LOCAL_AW-1:0];
                    if (r_miss_s) begin
                        r_sel_nxt    = '0;
                        s_rdata_nxt  = 32'h0000_0000;
                        s_rresp_nxt  = RESP_DECERR;
                        s_rvalid_nxt = 1'b1;
                        r_state_nxt  = R_RESP;
                    end else begin
                        r_sel_nxt     = slot_onehot(r_slot_s);
                        m_arvalid_nxt = slot_onehot(r_slot_s);
                        r_state_nxt   = R_FWD;
                    end
                end else begin
                    r_state_nxt = R_IDLE;
                end
            end
            R_FWD: begin
                m_arvalid_nxt = m_arvalid_r & ~m_arready;
                if (m_arvalid_nxt == '0) begin
                    m_rready_nxt = r_sel_r;
                    r_state_nxt  = R_WAIT;
                end else begin
                    r_state_nxt = R_FWD;
                end
            end
            R_WAIT: begin
                if ((m_rvalid & r_sel_r) != '0) begin
                    s_rdata_nxt  = rdata_sel_s;
                    s_rresp_nxt  = rresp_sel_s;
                    s_rvalid_nxt = 1'b1;
                    m_rready_nxt = '0;
                    r_state_nxt  = R_RESP;
                end else begin
                    r_state_nxt = R_WAIT;
                end
            end
            R_RESP: begin
                if (s_axi_rready) begin
                    s_rvalid_nxt = 1'b0;
                    r_state_nxt  = R_IDLE;
                end else begin
                    r_state_nxt = R_RESP;
                end
            end
            default: begin
                r_state_nxt = R_IDLE;
            end
        endcase
`ifdef AXIL_ROUTER_TIMEOUT_EN
        r_tmo_nxt   = 16'd0;
        r_tmo_hit_s = 1'b0;
        if ((r_state_r == R_FWD) || (r_state_r == R_WAIT)) begin
            if ((r_tmo_r == TMO_LAST) && (r_state_nxt != R_RESP)) begin
                r_tmo_hit_s   = 1'b1;
                m_arvalid_nxt = '0;
                m_rready_nxt  = '0;
                s_rdata_nxt   = 32'hDEAD_BEEF;
                s_rresp_nxt   = RESP_SLVERR;
                s_rvalid_nxt  = 1'b1;
                r_state_nxt   = R_RESP;
            end else begin
                r_tmo_nxt = r_tmo_r + 16'd1;
            end
        end else begin
            r_tmo_nxt = 16'd0;
        end
`endif
    end

    // Write-side register bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_r   <= W_IDLE;
            w_sel_r     <= '0;
            w_idle_r    <= 1'b0;
            m_awaddr_r  <= '0;
            m_wdata_r   <= 32'h0000_0000;
            m_wstrb_r   <= 4'h0;
            m_awvalid_r <= '0;
            m_wvalid_r  <= '0;
            m_bready_r  <= '0;
            s_bvalid_r  <= 1'b0;
            s_bresp_r   <= 2'b00;
        end else begin
            w_state_r   <= w_state_nxt;
            w_sel_r     <= w_sel_nxt;
            w_idle_r    <= (w_state_nxt == W_IDLE);
            m_awaddr_r  <= m_awaddr_nxt;
            m_wdata_r   <= m_wdata_nxt;
            m_wstrb_r   <= m_wstrb_nxt;
            m_awvalid_r <= m_awvalid_nxt;
            m_wvalid_r  <= m_wvalid_nxt;
            m_bready_r  <= m_bready_nxt;
            s_bvalid_r  <= s_bvalid_nxt;
            s_bresp_r   <= s_bresp_nxt;
        end
    end

    // Read-side register bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_r   <= R_IDLE;
            r_sel_r     <= '0;
            r_idle_r    <= 1'b0;
            m_araddr_r  <= '0;
            m_arvalid_r <= '0;
            m_rready_r  <= '0;
            s_rvalid_r  <= 1'b0;
            s_rresp_r   <= 2'b00;
            s_rdata_r   <= 32'h0000_0000;
        end else begin
            r_state_r   <= r_state_nxt;
            r_sel_r     <= r_sel_nxt;
            r_idle_r    <= (r_state_nxt == R_IDLE);
            m_araddr_r  <= m_araddr_nxt;
            m_arvalid_r <= m_arvalid_nxt;
            m_rready_r  <= m_rready_nxt;
            s_rvalid_r  <= s_rvalid_nxt;
            s_rresp_r   <= s_rresp_nxt;
            s_rdata_r   <= s_rdata_nxt;
        end
    end

`ifdef AXIL_ROUTER_TIMEOUT_EN
    // Watchdog counters and the sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_tmo_r        <= 16'd0;
            r_tmo_r        <= 16'd0;
            timeout_flag_r <= 1'b0;
        end else begin
            w_tmo_r        <= w_tmo_nxt;
            r_tmo_r        <= r_tmo_nxt;
            timeout_flag_r <= timeout_flag_r | w_tmo_hit_s | r_tmo_hit_s;
        end
    end

    assign timeout_flag = timeout_flag_r;
`endif

    assign s_axi_awready = w_accept_s;
    assign s_axi_wready  = w_accept_s;
    assign s_axi_bvalid  = s_bvalid_r;
    assign s_axi_bresp   = s_bresp_r;
    assign s_axi_arready = r_idle_r;
    assign s_axi_rvalid  = s_rvalid_r;
    assign s_axi_rresp   = s_rresp_r;
    assign s_axi_rdata   = s_rdata_r;
    assign m_awaddr      = m_awaddr_r;
    assign m_wdata       = m_wdata_r;
    assign m_wstrb       = m_wstrb_r;
    assign m_awvalid     = m_awvalid_r;
    assign m_wvalid      = m_wvalid_r;
    assign m_bready      = m_bready_r;
    assign m_araddr      = m_araddr_r;
    assign m_arvalid     = m_arvalid_r;
    assign m_rready      = m_rready_r;

endmodule

// File: tb/tb_axil_periph_router.sv
// ---------------------------------------------------------------------------
// tb_axil_periph_router
//
// Directed bench for axil_periph_router with NUM_SLOTS=4, LOCAL_AW=6 and
// SLOT_LSB=8. The bench plays the processor and all peripherals by driving
// the handshake inputs step by step. Expected values are hand-computed
// constants. Inputs change 1 time unit after the rising edge; outputs are
// checked after that as well.
// ---------------------------------------------------------------------------
module tb_axil_periph_router;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int LA = 6;

    logic            clk;
    logic            rst;
    logic [AW-1:0]   s_axi_awaddr;
    logic            s_axi_awvalid;
    logic            s_axi_awready;
    logic [31:0]     s_axi_wdata;
    logic [3:0]      s_axi_wstrb;
    logic            s_axi_wvalid;
    logic            s_axi_wready;
    logic [1:0]      s_axi_bresp;
    logic            s_axi_bvalid;
    logic            s_axi_bready;
    logic [AW-1:0]   s_axi_araddr;
    logic            s_axi_arvalid;
    logic            s_axi_arready;
    logic [31:0]     s_axi_rdata;
    logic [1:0]      s_axi_rresp;
    logic            s_axi_rvalid;
    logic            s_axi_rready;
    logic [LA-1:0]   m_awaddr;
    logic [31:0]     m_wdata;
    logic [3:0]      m_wstrb;
    logic [NS-1:0]   m_awvalid;
    logic [NS-1:0]   m_awready;
    logic [NS-1:0]   m_wvalid;
    logic [NS-1:0]   m_wready;
    logic [2*NS-1:0] m_bresp;
    logic [NS-1:0]   m_bvalid;
    logic [NS-1:0]   m_bready;
    logic [LA-1:0]   m_araddr;
    logic [NS-1:0]   m_arvalid;
    logic [NS-1:0]   m_arready;
    logic [32*NS-1:0] m_rdata;
    logic [2*NS-1:0] m_rresp;
    logic [NS-1:0]   m_rvalid;
    logic [NS-1:0]   m_rready;
`ifdef AXIL_ROUTER_TIMEOUT_EN
    logic            timeout_flag;
`endif

    int vectors;
    int miscompares;

    axil_periph_router #(
        .NUM_SLOTS(NS),
        .ADDR_W   (AW),
        .LOCAL_AW (LA),
        .SLOT_LSB (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axi_awaddr (s_axi_awaddr),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata  (s_axi_wdata),
        .s_axi_wstrb  (s_axi_wstrb),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .m_awaddr     (m_awaddr),
        .m_wdata      (m_wdata),
        .m_wstrb      (m_wstrb),
        .m_awvalid    (m_awvalid),
        .m_awready    (m_awready),
        .m_wvalid     (m_wvalid),
        .m_wready     (m_wready),
        .m_bresp      (m_bresp),
        .m_bvalid     (m_bvalid),
        .m_bready     (m_bready),
        .m_araddr     (m_araddr),
        .m_arvalid    (m_arvalid),
        .m_arready    (m_arready),
        .m_rdata      (m_rdata),
        .m_rresp      (m_rresp),
        .m_rvalid     (m_rvalid),
        .m_rready     (m_rready)
`ifdef AXIL_ROUTER_TIMEOUT_EN
        ,
        .timeout_flag (timeout_flag)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        s_axi_awaddr  = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_araddr  = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        m_awready     = '0;
        m_wready      = '0;
        m_bresp       = '0;
        m_bvalid      = '0;
        m_arready     = '0;
        m_rdata       = '0;
        m_rresp       = '0;
        m_rvalid      = '0;

        // ---- reset state ----
        tick();
        tick();
        check("rst_arready", 64'(s_axi_arready), 64'h0);
        check("rst_bvalid",  64'(s_axi_bvalid),  64'h0);
        check("rst_rvalid",  64'(s_axi_rvalid),  64'h0);
        check("rst_awvalid", 64'(m_awvalid),     64'h0);
        check("rst_arvalid", 64'(m_arvalid),     64'h0);
        check("rst_bresp",   64'(s_axi_bresp),   64'h0);
        rst = 1'b0;
        tick();
        check("idle_arready", 64'(s_axi_arready), 64'h1);

        // ---- write 0xA5A5_0001 to 0x104 (slot 1) ----
        s_axi_awaddr  = 32'h0000_0104;
        s_axi_wdata   = 32'hA5A5_0001;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        #1;
        check("w1_awready", 64'(s_axi_awready), 64'h1);
        check("w1_wready",  64'(s_axi_wready),  64'h1);
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        check("w1_m_awvalid", 64'(m_awvalid), 64'h2);
        check("w1_m_wvalid",  64'(m_wvalid),  64'h2);
        check("w1_m_awaddr",  64'(m_awaddr),  64'h04);
        check("w1_m_wdata",   64'(m_wdata),   64'hA5A5_0001);
        check("w1_m_wstrb",   64'(m_wstrb),   64'hF);
        m_awready = 4'b0010;
        m_wready  = 4'b0010;
        tick();
        m_awready = 4'b0000;
        m_wready  = 4'b0000;
        check("w1_awvalid_drop", 64'(m_awvalid), 64'h0);
        check("w1_wvalid_drop",  64'(m_wvalid),  64'h0);
        check("w1_m_bready",     64'(m_bready),  64'h2);
        tick();
        tick();
        check("w1_bvalid_wait", 64'(s_axi_bvalid), 64'h0);
        m_bresp  = 8'b11_11_00_11;
        m_bvalid = 4'b0010;
        tick();
        m_bvalid = 4'b0000;
        check("w1_bvalid",       64'(s_axi_bvalid), 64'h1);
        check("w1_bresp",        64'(s_axi_bresp),  64'h0);
        check("w1_bready_drop",  64'(m_bready),     64'h0);
        tick();
        check("w1_bvalid_hold",  64'(s_axi_bvalid), 64'h1);
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check("w1_bvalid_done",  64'(s_axi_bvalid), 64'h0);

        // ---- read 0x308 (slot 3) ----
        s_axi_araddr  = 32'h0000_0308;
        s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        check("r1_m_arvalid", 64'(m_arvalid),     64'h8);
        check("r1_m_araddr",  64'(m_araddr),      64'h08);
        check("r1_arready",   64'(s_axi_arready), 64'h0);
        m_arready = 4'b1000;
        tick();
        m_arready = 4'b0000;
        check("r1_arvalid_drop", 64'(m_arvalid), 64'h0);
        check("r1_m_rready",     64'(m_rready),  64'h8);
        m_rdata  = {32'h1234_5678, 32'hFFFF_FFFF, 32'hEEEE_EEEE, 32'hDDDD_DDDD};
        m_rresp  = 8'b00_11_11_11;
        m_rvalid = 4'b1000;
        tick();
        m_rvalid = 4'b0000;
        check("r1_rvalid", 64'(s_axi_rvalid), 64'h1);
        check("r1_rdata",  64'(s_axi_rdata),  64'h1234_5678);
        check("r1_rresp",  64'(s_axi_rresp),  64'h0);
        tick();
        check("r1_rvalid_hold", 64'(s_axi_rvalid), 64'h1);
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        check("r1_rvalid_done", 64'(s_axi_rvalid), 64'h0);

        // ---- read decode miss 0x700 ----
        s_axi_araddr  = 32'h0000_0700;
        s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        check("r2_m_arvalid", 64'(m_arvalid),     64'h0);
        check("r2_rvalid",    64'(s_axi_rvalid),  64'h1);
        check("r2_rresp",     64'(s_axi_rresp),   64'h3);
        check("r2_rdata",     64'(s_axi_rdata),   64'h0);
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        check("r2_rvalid_done", 64'(s_axi_rvalid), 64'h0);

        // ---- write decode miss 0x500 ----
        s_axi_awaddr  = 32'h0000_0500;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        check("w2_m_awvalid", 64'(m_awvalid),    64'h0);
        check("w2_bvalid",    64'(s_axi_bvalid), 64'h1);
        check("w2_bresp",     64'(s_axi_bresp),  64'h3);
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;

        // ---- AW two cycles ahead of W; W accepted before AW downstream ----
        s_axi_awaddr  = 32'h0000_0010;
        s_axi_awvalid = 1'b1;
        #1;
        check("w3_awready_early", 64'(s_axi_awready), 64'h0);
        tick();
        check("w3_awready_early2", 64'(s_axi_awready), 64'h0);
        check("w3_no_fwd",         64'(m_awvalid),     64'h0);
        tick();
        s_axi_wdata  = 32'hCAFE_0000;
        s_axi_wstrb  = 4'h3;
        s_axi_wvalid = 1'b1;
        #1;
        check("w3_awready", 64'(s_axi_awready), 64'h1);
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        check("w3_m_awvalid", 64'(m_awvalid), 64'h1);
        check("w3_m_awaddr",  64'(m_awaddr),  64'h10);
        check("w3_m_wstrb",   64'(m_wstrb),   64'h3);
        m_wready = 4'b0001;
        tick();
        m_wready = 4'b0000;
        check("w3_wvalid_drop",  64'(m_wvalid),  64'h0);
        check("w3_awvalid_keep", 64'(m_awvalid), 64'h1);
        check("w3_bready_early", 64'(m_bready),  64'h0);
        m_awready = 4'b0001;
        tick();
        m_awready = 4'b0000;
        check("w3_awvalid_drop", 64'(m_awvalid), 64'h0);
        check("w3_m_bready",     64'(m_bready),  64'h1);
        m_bresp  = 8'b00_00_00_10;
        m_bvalid = 4'b0001;
        tick();
        m_bvalid = 4'b0000;
        check("w3_bresp",      64'(s_axi_bresp), 64'h2);
        check("w3_single_aw",  64'(m_awvalid),   64'h0);
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check("w3_bvalid_done", 64'(s_axi_bvalid), 64'h0);

        // ---- concurrent write slot 0 / read slot 2, reset during W_RESP ----
        s_axi_awaddr  = 32'h0000_0020;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_araddr  = 32'h0000_0204;
        s_axi_arvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_arvalid = 1'b0;
        check("c_m_awvalid", 64'(m_awvalid), 64'h1);
        check("c_m_arvalid", 64'(m_arvalid), 64'h4);
        m_awready = 4'b0001;
        m_wready  = 4'b0001;
        m_arready = 4'b0100;
        tick();
        m_awready = 4'b0000;
        m_wready  = 4'b0000;
        m_arready = 4'b0000;
        check("c_m_bready", 64'(m_bready), 64'h1);
        check("c_m_rready", 64'(m_rready), 64'h4);
        rst = 1'b1;
        tick();
        check("c_rst_bready",  64'(m_bready),      64'h0);
        check("c_rst_rready",  64'(m_rready),      64'h0);
        check("c_rst_arready", 64'(s_axi_arready), 64'h0);
        check("c_rst_bvalid",  64'(s_axi_bvalid),  64'h0);
        check("c_rst_awaddr",  64'(m_awaddr),      64'h0);
        rst = 1'b0;
        tick();
        check("c_post_arready", 64'(s_axi_arready), 64'h1);
        s_axi_araddr  = 32'h0000_0104;
        s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        check("c_r_m_arvalid", 64'(m_arvalid), 64'h2);
        m_arready = 4'b0010;
        tick();
        m_arready = 4'b0000;
        m_rdata   = {32'h1111_1111, 32'h2222_2222, 32'h0BAD_F00D, 32'h3333_3333};
        m_rresp   = 8'b11_11_01_11;
        m_rvalid  = 4'b0010;
        tick();
        m_rvalid = 4'b0000;
        check("c_r_rdata",    64'(s_axi_rdata),  64'h0BAD_F00D);
        check("c_r_rresp",    64'(s_axi_rresp),  64'h1);
        check("c_no_bvalid",  64'(s_axi_bvalid), 64'h0);
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        check("c_r_done", 64'(s_axi_rvalid), 64'h0);

`ifdef AXIL_ROUTER_TIMEOUT_EN
        // ---- slot 2 never accepts the read address ----
        begin
            int n;
            check("t_flag_clear", 64'(timeout_flag), 64'h0);
            s_axi_araddr  = 32'h0000_0200;
            s_axi_arvalid = 1'b1;
            tick();
            s_axi_arvalid = 1'b0;
            n = 0;
            for (int i = 0; i < 1100; i++) begin
                tick();
                n++;
                if (s_axi_rvalid) break;
            end
            check("t_cycles",  64'(n),            64'd1024);
            check("t_rvalid",  64'(s_axi_rvalid), 64'h1);
            check("t_rresp",   64'(s_axi_rresp),  64'h2);
            check("t_rdata",   64'(s_axi_rdata),  64'hDEAD_BEEF);
            check("t_arvalid", 64'(m_arvalid),    64'h0);
            check("t_flag",    64'(timeout_flag), 64'h1);
            s_axi_rready = 1'b1;
            tick();
            s_axi_rready = 1'b0;
            check("t_flag_sticky", 64'(timeout_flag), 64'h1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
